// File: rtl/nfc_frame_sequencer.sv
// nfc_frame_sequencer: buffers one parsed NFC frame, replays it to the transmitter over
// valid/ready, then blocks new frames until rx_done or timeout. Optional retry via NFC_SEQ_RETRY_EN.
module nfc_frame_sequencer #(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`ifdef NFC_SEQ_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY      = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [3:0] in_datab,
    input  logic       in_last,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [3:0] tx_datab,
    output logic       tx_last,
    input  logic       rx_done,
    output logic       busy,
    output logic       frame_drop,
    output logic       timeout
);

    localparam int unsigned PW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] MAX_PTR  = PW'(MAX_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
`ifdef NFC_SEQ_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT    = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t        state;
    logic [7:0]    mem [MAX_LEN];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] len;
    logic [3:0]    last_datab;
    logic [CW-1:0] wait_cnt;
`ifdef NFC_SEQ_RETRY_EN
    logic [RW-1:0] retry_cnt;
`endif

    logic [PW-1:0] rd_next;
    logic [PW-1:0] len_m1;
    logic          mem_we;
    logic          discard_last;

    assign rd_next = rd_ptr + PW'(1);
    assign len_m1  = len - PW'(1);
    assign mem_we  = in_valid && ((state == IDLE) || ((state == COLLECT) && (wr_ptr != MAX_PTR)));
    assign discard_last = in_valid && in_last &&
                          ((state == LOAD) || (state == SEND) || (state == WAIT));

    // Frame storage; read combinationally so the next byte can follow each handshake directly.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[AW'(wr_ptr)] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            last_datab <= 4'd8;
            wait_cnt   <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
            tx_datab   <= 4'd8;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
            frame_drop <= 1'b0;
            timeout    <= 1'b0;
`ifdef NFC_SEQ_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            frame_drop <= discard_last;
            timeout    <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (in_valid) begin
                        if (wr_ptr == MAX_PTR) begin
                            // Overflow: drop once, then skip the rest of the frame if it continues.
                            frame_drop <= 1'b1;
                            wr_ptr     <= '0;
                            state      <= in_last ? IDLE : DRAIN;
                            busy       <= ~in_last;
                        end else if (in_last) begin
                            len        <= wr_ptr + PW'(1);
                            last_datab <= ((in_datab == 4'd0) || (in_datab > 4'd8)) ? 4'd8 : in_datab;
                            rd_ptr     <= '0;
                            wr_ptr     <= '0;
                            state      <= LOAD;
                            busy       <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                            state  <= COLLECT;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    tx_valid <= 1'b1;
                    tx_data  <= mem[AW'(rd_ptr)];
                    tx_last  <= (rd_ptr == len_m1);
                    tx_datab <= (rd_ptr == len_m1) ? last_datab : 4'd8;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (tx_last) begin
                            tx_valid <= 1'b0;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            rd_ptr   <= rd_next;
                            tx_data  <= mem[AW'(rd_next)];
                            tx_last  <= (rd_next == len_m1);
                            tx_datab <= (rd_next == len_m1) ? last_datab : 4'd8;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (rx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef NFC_SEQ_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end else if (wait_cnt == LAST_CNT) begin
`ifdef NFC_SEQ_RETRY_EN
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            rd_ptr    <= '0;
                            state     <= LOAD;
                        end else begin
                            retry_cnt <= '0;
                            timeout   <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
`else
                        timeout <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nfc_frame_sequencer.sv
// Bench for nfc_frame_sequencer: directed scenarios plus random frames checked against a
// frame-level model (expected byte stream, bit counts, response/timeout timing).
module tb_nfc_frame_sequencer;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned TMO     = 16;
`ifdef NFC_SEQ_RETRY_EN
    localparam int unsigned RETRIES = 2;
`else
    localparam int unsigned RETRIES = 0;
`endif

    typedef logic [7:0] byteq_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] in_datab;
    logic       in_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [3:0] tx_datab;
    logic       tx_last;
    logic       rx_done;
    logic       busy;
    logic       frame_drop;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nfc_frame_sequencer #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
`ifdef NFC_SEQ_RETRY_EN
        ,
        .MAX_RETRY      (RETRIES)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_datab   (in_datab),
        .in_last    (in_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_datab   (tx_datab),
        .tx_last    (tx_last),
        .rx_done    (rx_done),
        .busy       (busy),
        .frame_drop (frame_drop),
        .timeout    (timeout)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] d, input logic l, input logic [3:0] db);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_datab = db;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic put_frame(input byteq_t f, input logic [3:0] db);
        for (int i = 0; i < f.size(); i++) put_byte(f[i], (i == f.size() - 1), db);
    endtask

    // Called in the cycle after in_last was accepted; consumes the frame on the TX side.
    // mode 0: ready always high, 1: random ready, 2: ready pattern 0,0,1.
    task automatic receive_frame(input byteq_t f, input logic [3:0] db, input int mode);
        int n;
        int idx;
        int cycles;
        logic r;
        logic [3:0] exp_db;
        logic [7:0] e_data;
        logic [3:0] e_datab;
        logic e_last;
        n = f.size();
        exp_db = ((db == 4'd0) || (db > 4'd8)) ? 4'd8 : db;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_cycle got valid=%b busy=%b exp valid=0 busy=1", tx_valid, busy);
        end
        cyc();
        total++;
        if (tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL tx_rise_latency got valid=%b exp valid=1", tx_valid);
        end
        idx = 0;
        cycles = 0;
        while (idx < n && cycles < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cycles % 3 == 2);
            endcase
            e_data  = f[idx];
            e_last  = (idx == n - 1);
            e_datab = e_last ? exp_db : 4'd8;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== e_data || tx_datab !== e_datab ||
                tx_last !== e_last || busy !== 1'b1) begin
                bad++;
                $display("FAIL tx_byte%0d got v=%b d=%h db=%0d l=%b busy=%b exp v=1 d=%h db=%0d l=%b busy=1",
                         idx, tx_valid, tx_data, tx_datab, tx_last, busy, e_data, e_datab, e_last);
            end
            tx_ready = r;
            if (r) idx++;
            cyc();
            cycles++;
        end
        tx_ready = 1'b0;
        total++;
        if (idx != n) begin
            bad++;
            $display("FAIL tx_frame_bound got bytes=%0d exp bytes=%0d", idx, n);
        end
        if (mode == 0 || mode == 2) begin
            total++;
            if (cycles != ((mode == 0) ? n : 3 * n)) begin
                bad++;
                $display("FAIL tx_throughput got cycles=%0d exp cycles=%0d", cycles, (mode == 0) ? n : 3 * n);
            end
        end
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_last got valid=%b busy=%b exp valid=0 busy=1", tx_valid, busy);
        end
    endtask

    // rx_done sampled on the k-th edge after the final handshake.
    task automatic expect_rx(input int k);
        for (int j = 1; j <= k; j++) begin
            rx_done = (j == k);
            cyc();
            rx_done = 1'b0;
            total++;
            if (timeout !== 1'b0 || busy !== (j < k) || tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL rx_wait%0d got timeout=%b busy=%b valid=%b exp timeout=0 busy=%b valid=0",
                         j, timeout, busy, tx_valid, (j < k));
            end
        end
        cyc();
        total++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rx_after got timeout=%b busy=%b exp timeout=0 busy=0", timeout, busy);
        end
    endtask

    // No response: every expiry but the last resends the frame; the last pulses timeout.
    task automatic expect_timeout(input byteq_t f, input logic [3:0] db);
        logic fin;
        for (int a = 0; a <= int'(RETRIES); a++) begin
            for (int k = 1; k <= int'(TMO); k++) begin
                cyc();
                fin = (k == int'(TMO)) && (a == int'(RETRIES));
                total++;
                if (timeout !== fin || busy !== !fin) begin
                    bad++;
                    $display("FAIL timeout_a%0d_k%0d got timeout=%b busy=%b exp timeout=%b busy=%b",
                             a, k, timeout, busy, fin, !fin);
                end
            end
            if (a < int'(RETRIES)) receive_frame(f, db, 1);
        end
        cyc();
        total++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_single got timeout=%b busy=%b exp timeout=0 busy=0", timeout, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_datab = 4'd0; in_last = 1'b0;
        tx_ready = 1'b0; rx_done = 1'b0;
        cyc();
        cyc();
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'd0 || tx_datab !== 4'd8 || tx_last !== 1'b0 ||
            busy !== 1'b0 || frame_drop !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b d=%h db=%0d l=%b busy=%b drop=%b to=%b exp 0,00,8,0,0,0,0",
                     tx_valid, tx_data, tx_datab, tx_last, busy, frame_drop, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        byteq_t f;
        f = '{8'h26, 8'h00, 8'h7F};
        put_frame(f, 4'd7);
        receive_frame(f, 4'd7, 0);
        expect_rx(5);
    endtask

    task automatic test_single_stall();
        byteq_t f;
        f = '{8'h26};
        put_frame(f, 4'd7);
        receive_frame(f, 4'd7, 2);
        expect_rx(10);
    endtask

    task automatic test_overflow();
        byteq_t f;
        for (int i = 1; i <= 5; i++) begin
            put_byte(8'(i), (i == 5), 4'd3);
            total++;
            if (frame_drop !== (i == 5) || busy !== 1'b0) begin
                bad++;
                $display("FAIL ovf_byte%0d got drop=%b busy=%b exp drop=%b busy=0", i, frame_drop, busy, (i == 5));
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (tx_valid !== 1'b0 || frame_drop !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ovf_idle got valid=%b drop=%b busy=%b exp 0,0,0", tx_valid, frame_drop, busy);
            end
        end
        f = '{8'hA5, 8'h5A};
        put_frame(f, 4'd4);
        receive_frame(f, 4'd4, 1);
        expect_rx(5);
        // Overflow without in_last: drain the rest of the frame.
        for (int i = 1; i <= 7; i++) begin
            put_byte(8'(i), (i == 7), 4'd8);
            total++;
            if (frame_drop !== (i == 5) || busy !== (i == 5 || i == 6) || tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL drain_byte%0d got drop=%b busy=%b valid=%b exp drop=%b busy=%b valid=0",
                         i, frame_drop, busy, tx_valid, (i == 5), (i == 5 || i == 6));
            end
        end
        f = '{8'h11, 8'h22, 8'h33, 8'h44};
        put_frame(f, 4'd0);
        receive_frame(f, 4'd0, 0);
        expect_rx(1);
    endtask

    task automatic test_drop_in_wait();
        byteq_t f;
        f = '{8'h93, 8'h20};
        put_frame(f, 4'd8);
        receive_frame(f, 4'd8, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; end
            if (k == 4) begin in_valid = 1'b1; in_data = 8'hBB; in_last = 1'b1; in_datab = 4'd8; end
            rx_done = (k == 10);
            cyc();
            in_valid = 1'b0; in_last = 1'b0; rx_done = 1'b0;
            total++;
            if (frame_drop !== (k == 4) || tx_valid !== 1'b0 || busy !== (k < 10) || timeout !== 1'b0) begin
                bad++;
                $display("FAIL wait_drop%0d got drop=%b valid=%b busy=%b to=%b exp drop=%b valid=0 busy=%b to=0",
                         k, frame_drop, tx_valid, busy, timeout, (k == 4), (k < 10));
            end
        end
        f = '{8'h50};
        put_frame(f, 4'd12);
        receive_frame(f, 4'd12, 0);
        expect_rx(3);
    endtask

    task automatic test_timeout();
        byteq_t f;
        f = '{8'h30, 8'h01};
        put_frame(f, 4'd5);
        receive_frame(f, 4'd5, 0);
        expect_timeout(f, 4'd5);
        f = '{8'h60};
        put_frame(f, 4'd1);
        receive_frame(f, 4'd1, 0);
        expect_rx(int'(TMO));
    endtask

    task automatic test_reset_mid_send();
        byteq_t f;
        f = '{8'hC1, 8'hC2, 8'hC3};
        put_frame(f, 4'd6);
        cyc();
        tx_ready = 1'b1;
        cyc();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hC2) begin
            bad++;
            $display("FAIL pre_reset_byte1 got valid=%b d=%h exp valid=1 d=c2", tx_valid, tx_data);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_drop !== 1'b0 || tx_last !== 1'b0 || tx_datab !== 4'd8) begin
            bad++;
            $display("FAIL mid_send_reset got valid=%b busy=%b drop=%b l=%b db=%0d exp 0,0,0,0,8",
                     tx_valid, busy, frame_drop, tx_last, tx_datab);
        end
        f = '{8'hD0, 8'hD1, 8'hD2};
        put_frame(f, 4'd2);
        receive_frame(f, 4'd2, 1);
        expect_rx(7);
    endtask

    task automatic test_random();
        byteq_t f;
        int n;
        logic [3:0] db;
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(1, MAX_LEN);
            db = 4'($urandom_range(0, 15));
            f = {};
            for (int i = 0; i < n; i++) f.push_back(8'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
            put_frame(f, db);
            receive_frame(f, db, 1);
            if ($urandom_range(0, 3) == 0) expect_timeout(f, db);
            else expect_rx($urandom_range(1, TMO));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_stall();
        test_overflow();
        test_drop_in_wait();
        test_timeout();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
